// File: rtl/sha256_compress.sv
// SHA-256 compression engine: one 512-bit block in, 64 rounds at one round per
// cycle, then the chaining state is updated and presented as a 256-bit digest.
module sha256_compress (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic [255:0] iv_in,
  output logic [6:0]   k_idx,
  input  logic [31:0]  k_t,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  t;
  logic [31:0] hv [8];
  logic [31:0] wv [8];
  logic [31:0] w  [16];
  logic [31:0] t1, t2, w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DONE has priority over a waiting block: the digest handshake must retire
  // before IDLE can accept again, so blk_ready stays low throughout DONE.
  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    dig_valid = 1'b0;
    k_idx     = 7'd0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) state_nxt = ROUND;
      end
      ROUND: begin
        k_idx = {1'b0, t};
        if (t == 6'd63) state_nxt = FINAL;
      end
      FINAL: state_nxt = DONE;
      DONE: begin
        dig_valid = 1'b1;
        if (dig_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign t1    = wv[7] + bsig1(wv[4]) + ch(wv[4], wv[5], wv[6]) + k_t + w[0];
  assign t2    = bsig0(wv[0]) + maj(wv[0], wv[1], wv[2]);
  assign w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      t <= 6'd0;
      for (int i = 0; i < 8; i++) begin
        hv[i] <= 32'd0;
        wv[i] <= 32'd0;
      end
      for (int i = 0; i < 16; i++) w[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            t <= 6'd0;
            for (int i = 0; i < 16; i++) w[i] <= blk_data[511 - 32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              if (blk_first) begin
                hv[i] <= iv_in[255 - 32*i -: 32];
                wv[i] <= iv_in[255 - 32*i -: 32];
              end else begin
                wv[i] <= hv[i];
              end
            end
          end
        end
        ROUND: begin
          wv[0] <= t1 + t2;
          wv[1] <= wv[0];
          wv[2] <= wv[1];
          wv[3] <= wv[2];
          wv[4] <= wv[3] + t1;
          wv[5] <= wv[4];
          wv[6] <= wv[5];
          wv[7] <= wv[6];
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          if (t != 6'd63) t <= t + 6'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
        end
        default: ;
      endcase
    end
  end

  assign digest = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};

endmodule
